// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath width, control-bundle layout and ALU
// op encodings used by the decode/execute pipeline.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 12;

  // Control bundle bit positions
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_BRANCH     = 5;
  localparam int CTRL_JUMP       = 6;
  localparam int CTRL_ALU_OP_LSB = 7;
  localparam int CTRL_ALU_OP_W   = 4;
  localparam int CTRL_SPARE      = 11;

  localparam int REG_IDX_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_PASS = 4'd10
  } alu_op_e;

  function automatic logic ctrl_mem_read(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEM_READ];
  endfunction

  function automatic logic ctrl_reg_write(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_REG_WRITE];
  endfunction

  function automatic alu_op_e ctrl_alu_op(input logic [CTRL_W-1:0] ctrl);
    return alu_op_e'(ctrl[CTRL_ALU_OP_LSB +: CTRL_ALU_OP_W]);
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Combinational load-use hazard term: a load in EX whose destination is read
// by the valid instruction currently in ID.
module load_use_detect
  import core_pkg::*;
(
  input  logic                 i_ex_valid,
  input  logic                 i_ex_mem_read,
  input  logic [REG_IDX_W-1:0] i_ex_rd,
  input  logic                 i_id_valid,
  input  logic                 i_id_uses_rs1,
  input  logic [REG_IDX_W-1:0] i_id_rs1,
  input  logic                 i_id_uses_rs2,
  input  logic [REG_IDX_W-1:0] i_id_rs2,
  output logic                 o_hazard
);

  logic rs1_match_s;
  logic rs2_match_s;
  logic ex_load_s;

  // Source-operand match against a live, non-x0 load destination
  always_comb begin
    rs1_match_s = i_id_uses_rs1 & (i_id_rs1 == i_ex_rd);
    rs2_match_s = i_id_uses_rs2 & (i_id_rs2 == i_ex_rd);
    ex_load_s   = i_ex_valid & i_ex_mem_read & (i_ex_rd != 5'd0);
    if (ex_load_s && i_id_valid) begin
      o_hazard = rs1_match_s | rs2_match_s;
    end else begin
      o_hazard = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion and flush.
// Optional ID_EX_PERF_EN adds bubble/flush event counters.
module id_ex_pipe_reg
  import core_pkg::*;
#(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int CTRL_W = core_pkg::CTRL_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_id_valid,
  input  logic [XLEN-1:0]   i_id_pc,
  input  logic [XLEN-1:0]   i_id_rs1_data,
  input  logic [XLEN-1:0]   i_id_rs2_data,
  input  logic [XLEN-1:0]   i_id_imm,
  input  logic [4:0]        i_id_rs1,
  input  logic [4:0]        i_id_rs2,
  input  logic [4:0]        i_id_rd,
  input  logic              i_id_uses_rs1,
  input  logic              i_id_uses_rs2,
  input  logic [CTRL_W-1:0] i_id_ctrl,
  output logic              o_stall,
  output logic              o_ex_valid,
  output logic [XLEN-1:0]   o_ex_pc,
  output logic [XLEN-1:0]   o_ex_rs1_data,
  output logic [XLEN-1:0]   o_ex_rs2_data,
  output logic [XLEN-1:0]   o_ex_imm,
  output logic [4:0]        o_ex_rs1,
  output logic [4:0]        o_ex_rs2,
  output logic [4:0]        o_ex_rd,
  output logic [CTRL_W-1:0] o_ex_ctrl
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       o_bubble_cnt,
  output logic [31:0]       o_flush_cnt
`endif
);

  logic              ex_valid_q,    ex_valid_d;
  logic [XLEN-1:0]   ex_pc_q,       ex_pc_d;
  logic [XLEN-1:0]   ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0]   ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0]   ex_imm_q,      ex_imm_d;
  logic [4:0]        ex_rs1_q,      ex_rs1_d;
  logic [4:0]        ex_rs2_q,      ex_rs2_d;
  logic [4:0]        ex_rd_q,       ex_rd_d;
  logic [CTRL_W-1:0] ex_ctrl_q,     ex_ctrl_d;

  logic hazard_s;
  logic bubble_s;

  load_use_detect u_load_use_detect (
    .i_ex_valid    (ex_valid_q),
    .i_ex_mem_read (ex_ctrl_q[CTRL_MEM_READ]),
    .i_ex_rd       (ex_rd_q),
    .i_id_valid    (i_id_valid),
    .i_id_uses_rs1 (i_id_uses_rs1),
    .i_id_rs1      (i_id_rs1),
    .i_id_uses_rs2 (i_id_uses_rs2),
    .i_id_rs2      (i_id_rs2),
    .o_hazard      (hazard_s)
  );

  // Flush overrides the stall: the dependent instruction is killed upstream
  always_comb begin
    if (i_flush) begin
      bubble_s = 1'b0;
    end else begin
      bubble_s = hazard_s;
    end
  end

  assign o_stall = bubble_s;

  // Next-state priority mux: flush, then load-use bubble, then capture
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_imm_d      = ex_imm_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rd_d       = ex_rd_q;
    ex_ctrl_d     = ex_ctrl_q;
    if (i_flush || bubble_s) begin
      // Datapath fields deliberately hold so a bubble toggles nothing wide
      ex_valid_d = 1'b0;
      ex_ctrl_d  = {CTRL_W{1'b0}};
      ex_rd_d    = 5'd0;
      ex_rs1_d   = 5'd0;
      ex_rs2_d   = 5'd0;
    end else begin
      ex_valid_d    = i_id_valid;
      ex_pc_d       = i_id_pc;
      ex_rs1_data_d = i_id_rs1_data;
      ex_rs2_data_d = i_id_rs2_data;
      ex_imm_d      = i_id_imm;
      ex_rs1_d      = i_id_rs1;
      ex_rs2_d      = i_id_rs2;
      if (i_id_valid) begin
        ex_ctrl_d = i_id_ctrl;
        ex_rd_d   = i_id_rd;
      end else begin
        ex_ctrl_d = {CTRL_W{1'b0}};
        ex_rd_d   = 5'd0;
      end
    end
  end

  // ID/EX register bank
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= {XLEN{1'b0}};
      ex_rs1_data_q <= {XLEN{1'b0}};
      ex_rs2_data_q <= {XLEN{1'b0}};
      ex_imm_q      <= {XLEN{1'b0}};
      ex_rs1_q      <= 5'd0;
      ex_rs2_q      <= 5'd0;
      ex_rd_q       <= 5'd0;
      ex_ctrl_q     <= {CTRL_W{1'b0}};
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_ctrl_q     <= ex_ctrl_d;
    end
  end

  assign o_ex_valid    = ex_valid_q;
  assign o_ex_pc       = ex_pc_q;
  assign o_ex_rs1_data = ex_rs1_data_q;
  assign o_ex_rs2_data = ex_rs2_data_q;
  assign o_ex_imm      = ex_imm_q;
  assign o_ex_rs1      = ex_rs1_q;
  assign o_ex_rs2      = ex_rs2_q;
  assign o_ex_rd       = ex_rd_q;
  assign o_ex_ctrl     = ex_ctrl_q;

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] flush_cnt_q,  flush_cnt_d;

  // Event counters; a flush cycle is never also counted as a bubble
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (i_flush) begin
      if (ex_valid_q || i_id_valid) begin
        flush_cnt_d = flush_cnt_q + 32'd1;
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end else if (bubble_s) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bubble_cnt_q <= 32'd0;
      flush_cnt_q  <= 32'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign o_bubble_cnt = bubble_cnt_q;
  assign o_flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: reset, load-use bubble, false-stall
// filters, flush priority, invalid capture, streaming and async reset.
module tb_id_ex_pipe_reg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 12;

  // Hand-encoded control bundles (bit0 reg_write, 1 mem_read, 2 mem_write,
  // 3 mem_to_reg, 4 alu_src, 7..10 alu_op)
  localparam logic [11:0] C_ADDI = 12'h011;
  localparam logic [11:0] C_LW   = 12'h01B;
  localparam logic [11:0] C_ADD  = 12'h001;
  localparam logic [11:0] C_SW   = 12'h014;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic              id_uses_rs1, id_uses_rs2;
  logic [CTRL_W-1:0] id_ctrl;
  logic              stall;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
`ifdef ID_EX_PERF_EN
  logic [31:0]       bubble_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_flush       (flush),
    .i_id_valid    (id_valid),
    .i_id_pc       (id_pc),
    .i_id_rs1_data (id_rs1_data),
    .i_id_rs2_data (id_rs2_data),
    .i_id_imm      (id_imm),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_rd       (id_rd),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .i_id_ctrl     (id_ctrl),
    .o_stall       (stall),
    .o_ex_valid    (ex_valid),
    .o_ex_pc       (ex_pc),
    .o_ex_rs1_data (ex_rs1_data),
    .o_ex_rs2_data (ex_rs2_data),
    .o_ex_imm      (ex_imm),
    .o_ex_rs1      (ex_rs1),
    .o_ex_rs2      (ex_rs2),
    .o_ex_rd       (ex_rd),
    .o_ex_ctrl     (ex_ctrl)
`ifdef ID_EX_PERF_EN
    ,
    .o_bubble_cnt  (bubble_cnt),
    .o_flush_cnt   (flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] imm,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic [11:0] ctrl);
    id_valid = v;  id_pc = pc;  id_rs1_data = d1;  id_rs2_data = d2;  id_imm = imm;
    id_rs1 = r1;  id_rs2 = r2;  id_rd = rd;  id_uses_rs1 = u1;  id_uses_rs2 = u2;
    id_ctrl = ctrl;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset with random inputs
    rst_n = 1'b0;
    flush = $urandom_range(1, 0);
    drive(1'b1, $urandom, $urandom, $urandom, $urandom, 5'd6, 5'd6, 5'd6, 1'b1, 1'b1, C_LW);
    repeat (3) @(negedge clk);
    chk("rst_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_ctrl",  {52'd0, ex_ctrl},  64'd0);
    chk("rst_rd",    {59'd0, ex_rd},    64'd0);
    chk("rst_rs1",   {59'd0, ex_rs1},   64'd0);
    chk("rst_pc",    {32'd0, ex_pc},    64'd0);
    chk("rst_imm",   {32'd0, ex_imm},   64'd0);
    chk("rst_data",  {ex_rs1_data, ex_rs2_data}, 64'd0);
    chk("rst_stall", {63'd0, stall},    64'd0);
`ifdef ID_EX_PERF_EN
    chk("rst_cnt", {bubble_cnt, flush_cnt}, 64'd0);
`endif

    // Release, addi x5, x1, 7
    rst_n = 1'b1;
    flush = 1'b0;
    drive(1'b1, 32'h100, 32'hAAAA_0001, 32'h0, 32'd7, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_ADDI);
    step();
    chk("addi_rd",    {59'd0, ex_rd},    64'd5);
    chk("addi_valid", {63'd0, ex_valid}, 64'd1);
    chk("addi_ctrl",  {52'd0, ex_ctrl},  {52'd0, C_ADDI});
    chk("addi_pc",    {32'd0, ex_pc},    64'h100);

    // lw x6 then dependent add x7, x6, x2
    drive(1'b1, 32'h104, 32'h1000, 32'h0, 32'd8, 5'd2, 5'd0, 5'd6, 1'b1, 1'b0, C_LW);
    #1 chk("lw_no_stall", {63'd0, stall}, 64'd0);
    step();
    drive(1'b1, 32'h108, 32'h11, 32'h22, 32'h0, 5'd6, 5'd2, 5'd7, 1'b1, 1'b1, C_ADD);
    #1 chk("lu_stall", {63'd0, stall}, 64'd1);
    step();
    chk("lu_bubble_valid", {63'd0, ex_valid}, 64'd0);
    chk("lu_bubble_ctrl",  {52'd0, ex_ctrl},  64'd0);
    chk("lu_bubble_rd",    {59'd0, ex_rd},    64'd0);
    chk("lu_bubble_pc_held", {32'd0, ex_pc},  64'h104);
    chk("lu_stall_clear",  {63'd0, stall},    64'd0);
    step();
    chk("lu_add_rd",    {59'd0, ex_rd},    64'd7);
    chk("lu_add_valid", {63'd0, ex_valid}, 64'd1);
    chk("lu_add_data",  {ex_rs1_data, ex_rs2_data}, 64'h0000_0011_0000_0022);

    // lw x0 in EX never stalls
    drive(1'b1, 32'h10C, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, C_LW);
    step();
    drive(1'b1, 32'h110, 32'h0, 32'h0, 32'h4, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, C_LW);
    #1 chk("lw_x0_no_stall", {63'd0, stall}, 64'd0);
    step();
    chk("lw6_rd", {59'd0, ex_rd}, 64'd6);
    // lw x6 in EX: consumers that do not really read x6
    drive(1'b1, 32'h114, 32'h0, 32'h0, 32'h0, 5'd6, 5'd3, 5'd8, 1'b0, 1'b1, C_ADD);
    #1 chk("rs2_only_no_stall", {63'd0, stall}, 64'd0);
    drive(1'b1, 32'h114, 32'h0, 32'h0, 32'h0, 5'd1, 5'd6, 5'd8, 1'b1, 1'b0, C_ADD);
    #1 chk("unused_rs2_no_stall", {63'd0, stall}, 64'd0);
    drive(1'b0, 32'h114, 32'h0, 32'h0, 32'h0, 5'd6, 5'd6, 5'd8, 1'b1, 1'b1, C_ADD);
    #1 chk("invalid_id_no_stall", {63'd0, stall}, 64'd0);
    drive(1'b1, 32'h114, 32'h0, 32'h0, 32'h0, 5'd1, 5'd6, 5'd8, 1'b1, 1'b1, C_ADD);
    #1 chk("rs2_stall", {63'd0, stall}, 64'd1);

    // Flush during hazard: flush wins
    drive(1'b1, 32'h118, 32'h0, 32'h0, 32'h0, 5'd6, 5'd1, 5'd7, 1'b1, 1'b1, C_ADD);
    flush = 1'b1;
    #1 chk("flush_hz_stall", {63'd0, stall}, 64'd0);
    step();
    chk("flush_hz_valid", {63'd0, ex_valid}, 64'd0);
    chk("flush_hz_ctrl",  {52'd0, ex_ctrl},  64'd0);
    chk("flush_hz_idx",   {49'd0, ex_rd, ex_rs1, ex_rs2}, 64'd0);
    chk("flush_hz_pc_held", {32'd0, ex_pc}, 64'h110);

    // Flush of a valid sw
    drive(1'b1, 32'h11C, 32'h2000, 32'h55, 32'h10, 5'd3, 5'd4, 5'd0, 1'b1, 1'b1, C_SW);
    step();
    chk("flush_sw_valid", {63'd0, ex_valid}, 64'd0);
    chk("flush_sw_ctrl",  {52'd0, ex_ctrl},  64'd0);
    flush = 1'b0;

    // Invalid ID entry: ctrl and rd forced to zero, sources captured
    drive(1'b0, 32'h300, 32'h1, 32'h2, 32'h3, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, C_LW);
    step();
    chk("inv_valid", {63'd0, ex_valid}, 64'd0);
    chk("inv_ctrl",  {52'd0, ex_ctrl},  64'd0);
    chk("inv_rd",    {59'd0, ex_rd},    64'd0);
    chk("inv_rs1",   {59'd0, ex_rs1},   64'd3);
    chk("inv_pc",    {32'd0, ex_pc},    64'h300);

    // Eight back-to-back independent ALU ops
    for (int i = 0; i < 8; i++) begin
      logic [11:0] c;
      c = C_ADD | (12'(i) << 7);
      drive(1'b1, 32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i),
            32'h40 + 32'(i), 5'(i + 1), 5'(i + 2), 5'(i + 10), 1'b1, 1'b1, c);
      #1 chk("stream_stall", {63'd0, stall}, 64'd0);
      step();
      chk("stream_pc",   {32'd0, ex_pc},   64'h200 + 64'(4 * i));
      chk("stream_rd",   {59'd0, ex_rd},   64'(i + 10));
      chk("stream_idx",  {54'd0, ex_rs1, ex_rs2}, {54'd0, 5'(i + 1), 5'(i + 2)});
      chk("stream_data", {ex_rs1_data, ex_rs2_data},
          {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)});
      chk("stream_imm",  {32'd0, ex_imm},  64'h40 + 64'(i));
      chk("stream_ctrl", {51'd0, ex_valid, ex_ctrl}, {51'd0, 1'b1, c});
    end
`ifdef ID_EX_PERF_EN
    chk("perf_bubble", {32'd0, bubble_cnt}, 64'd1);
    chk("perf_flush",  {32'd0, flush_cnt},  64'd2);
`endif

    // Async reset while stalling
    drive(1'b1, 32'h400, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, C_LW);
    step();
    drive(1'b1, 32'h404, 32'h0, 32'h0, 32'h0, 5'd2, 5'd6, 5'd7, 1'b1, 1'b1, C_ADD);
    #1 chk("pre_rst_stall", {63'd0, stall}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", {63'd0, stall},    64'd0);
    chk("mid_rst_valid", {63'd0, ex_valid}, 64'd0);
    chk("mid_rst_ctrl",  {47'd0, ex_ctrl, ex_rd}, 64'd0);
    chk("mid_rst_pc",    {32'd0, ex_pc},    64'd0);
    #5 rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
